// File: rtl/vga_pong_render.sv
// Pong pixel-colour stage: per-frame game update during vertical blank, registered RGB332 output.
// Optional build macro VGA_BORDER_EN draws a 4-pixel border and moves walls/paddle clamps inward.

module vga_pong_render #(
    parameter logic [9:0] H_OFFSET   = 10'd144,
    parameter logic [9:0] V_OFFSET   = 10'd31,
    parameter logic [9:0] H_ACTIVE   = 10'd640,
    parameter logic [9:0] V_ACTIVE   = 10'd480,
    parameter logic [9:0] BALL_SIZE  = 10'd8,
    parameter logic [9:0] BALL_STEP  = 10'd2,
    parameter logic [9:0] PAD_WIDTH  = 10'd64,
    parameter logic [9:0] PAD_HEIGHT = 10'd8,
    parameter logic [9:0] PAD_Y      = 10'd456,
    parameter logic [9:0] PAD_STEP   = 10'd4,
    parameter logic [7:0] COL_BALL   = 8'hFC,
    parameter logic [7:0] COL_PAD    = 8'h1C,
    parameter logic [7:0] COL_BG     = 8'h00,
    parameter logic [7:0] COL_BORDER = 8'hE0
) (
    input  logic       Clk_Pixel,
    input  logic       Rst_N,
    input  logic [9:0] H_Pixel_Count,
    input  logic [9:0] V_Line_Count,
    input  logic       H_Enable_Write,
    input  logic       V_Enable_Write,
    input  logic       Btn_Left,
    input  logic       Btn_Right,
    input  logic       Pause,
    output logic [7:0] Rgb_Out,
    output logic       Frame_Tick,
    output logic       Miss_Pulse
);

`ifdef VGA_BORDER_EN
    localparam logic [9:0] LIM = 10'd4;
`else
    localparam logic [9:0] LIM = 10'd0;
`endif
    localparam logic [9:0] PAD_X_MAX   = H_ACTIVE - LIM - PAD_WIDTH;
    localparam logic [9:0] BALL_X_MAX  = H_ACTIVE - LIM - BALL_SIZE;
    localparam logic [9:0] BALL_Y_MISS = V_ACTIVE - BALL_SIZE;
    localparam logic [9:0] BLANK_LINE  = V_OFFSET + V_ACTIVE;
    localparam logic [9:0] PAD_X_INIT  = 10'd288;
    localparam logic [9:0] BALL_X_INIT = 10'd316;
    localparam logic [9:0] BALL_Y_INIT = 10'd236;

    typedef enum logic [1:0] {S_WAIT, S_PAD, S_BALL_X, S_BALL_Y} state_t;

    state_t     state_q, state_d;
    logic       btn_l_meta_q, btn_l_meta_d, btn_l_sync_q, btn_l_sync_d;
    logic       btn_r_meta_q, btn_r_meta_d, btn_r_sync_q, btn_r_sync_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [7:0] rgb_q, rgb_d;
    logic       frame_tick_q, frame_tick_d;
    logic       miss_pulse_q, miss_pulse_d;
    logic [9:0] pad_x_q, pad_x_d;
    logic [9:0] ball_x_q, ball_x_d;
    logic [9:0] ball_y_q, ball_y_d;
    logic       dir_right_q, dir_right_d;
    logic       dir_down_q, dir_down_d;
    logic       in_ball, in_pad, in_border, pad_hit;

    // Render pipeline: stage 1 converts counts to active coordinates, stage 2 picks the colour.
    always_comb begin
        btn_l_meta_d = Btn_Left;
        btn_l_sync_d = btn_l_meta_q;
        btn_r_meta_d = Btn_Right;
        btn_r_sync_d = btn_r_meta_q;
        x_d          = H_Pixel_Count - H_OFFSET;
        y_d          = V_Line_Count - V_OFFSET;
        frame_tick_d = (H_Pixel_Count == 10'd0) && (V_Line_Count == BLANK_LINE);

        in_ball = (x_q >= ball_x_q) && (x_q < ball_x_q + BALL_SIZE) &&
                  (y_q >= ball_y_q) && (y_q < ball_y_q + BALL_SIZE);
        in_pad  = (x_q >= pad_x_q) && (x_q < pad_x_q + PAD_WIDTH) &&
                  (y_q >= PAD_Y) && (y_q < PAD_Y + PAD_HEIGHT);
`ifdef VGA_BORDER_EN
        in_border = (x_q < 10'd4) || (x_q >= H_ACTIVE - 10'd4) || (y_q < 10'd4);
`else
        in_border = 1'b0;
`endif
        if (!(H_Enable_Write && V_Enable_Write)) rgb_d = 8'h00;
        else if (in_ball)                        rgb_d = COL_BALL;
        else if (in_pad)                         rgb_d = COL_PAD;
        else if (in_border)                      rgb_d = COL_BORDER;
        else                                     rgb_d = COL_BG;
    end

    // Game update: one state per cycle; comparisons precede subtraction so nothing underflows.
    always_comb begin
        state_d      = state_q;
        pad_x_d      = pad_x_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        dir_right_d  = dir_right_q;
        dir_down_d   = dir_down_q;
        miss_pulse_d = 1'b0;
        pad_hit = (ball_y_q + BALL_SIZE <= PAD_Y) &&
                  (ball_y_q + BALL_SIZE + BALL_STEP >= PAD_Y) &&
                  (ball_x_q + BALL_SIZE > pad_x_q) &&
                  (ball_x_q < pad_x_q + PAD_WIDTH);
        case (state_q)
            S_WAIT: begin
                if (frame_tick_q && !Pause) state_d = S_PAD;
            end
            S_PAD: begin
                state_d = S_BALL_X;
                if (btn_l_sync_q && !btn_r_sync_q) begin
                    if (pad_x_q < PAD_STEP + LIM) pad_x_d = LIM;
                    else                          pad_x_d = pad_x_q - PAD_STEP;
                end else if (btn_r_sync_q && !btn_l_sync_q) begin
                    if (pad_x_q + PAD_STEP >= PAD_X_MAX) pad_x_d = PAD_X_MAX;
                    else                                 pad_x_d = pad_x_q + PAD_STEP;
                end
            end
            S_BALL_X: begin
                state_d = S_BALL_Y;
                if (dir_right_q) begin
                    if (ball_x_q + BALL_STEP >= BALL_X_MAX) begin
                        ball_x_d    = BALL_X_MAX;
                        dir_right_d = 1'b0;
                    end else begin
                        ball_x_d = ball_x_q + BALL_STEP;
                    end
                end else if (ball_x_q <= LIM + BALL_STEP) begin
                    ball_x_d    = LIM;
                    dir_right_d = 1'b1;
                end else begin
                    ball_x_d = ball_x_q - BALL_STEP;
                end
            end
            S_BALL_Y: begin
                state_d = S_WAIT;
                if (!dir_down_q) begin
                    if (ball_y_q <= LIM + BALL_STEP) begin
                        ball_y_d   = LIM;
                        dir_down_d = 1'b1;
                    end else begin
                        ball_y_d = ball_y_q - BALL_STEP;
                    end
                end else if (pad_hit) begin
                    ball_y_d   = PAD_Y - BALL_SIZE;
                    dir_down_d = 1'b0;
                end else if (ball_y_q + BALL_STEP >= BALL_Y_MISS) begin
                    ball_x_d     = BALL_X_INIT;
                    ball_y_d     = BALL_Y_INIT;
                    dir_down_d   = 1'b0;
                    miss_pulse_d = 1'b1;
                end else begin
                    ball_y_d = ball_y_q + BALL_STEP;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge Clk_Pixel or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q      <= S_WAIT;
            btn_l_meta_q <= 1'b0;
            btn_l_sync_q <= 1'b0;
            btn_r_meta_q <= 1'b0;
            btn_r_sync_q <= 1'b0;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            rgb_q        <= 8'h00;
            frame_tick_q <= 1'b0;
            miss_pulse_q <= 1'b0;
            pad_x_q      <= PAD_X_INIT;
            ball_x_q     <= BALL_X_INIT;
            ball_y_q     <= BALL_Y_INIT;
            dir_right_q  <= 1'b1;
            dir_down_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_l_meta_q <= btn_l_meta_d;
            btn_l_sync_q <= btn_l_sync_d;
            btn_r_meta_q <= btn_r_meta_d;
            btn_r_sync_q <= btn_r_sync_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
            miss_pulse_q <= miss_pulse_d;
            pad_x_q      <= pad_x_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            dir_right_q  <= dir_right_d;
            dir_down_q   <= dir_down_d;
        end
    end

    assign Rgb_Out    = rgb_q;
    assign Frame_Tick = frame_tick_q;
    assign Miss_Pulse = miss_pulse_q;

endmodule

// File: tb/tb_vga_pong_render.sv
// Self-checking bench for vga_pong_render: drives counts/enables directly, compares every cycle
// against a frame-level game model; honours VGA_BORDER_EN the same way as the design.

module tb_vga_pong_render;

`ifdef VGA_BORDER_EN
    localparam int LIM = 4;
    localparam bit BORDER = 1'b1;
`else
    localparam int LIM = 0;
    localparam bit BORDER = 1'b0;
`endif
    localparam int H_OFF   = 144;
    localparam int V_OFF   = 31;
    localparam int BLANK_V = 511;
    localparam int PADMAX  = 640 - LIM - 64;
    localparam int XMAX    = 640 - LIM - 8;
    localparam int NX      = (XMAX - 316) / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hcnt, vcnt;
    logic       h_en, v_en, btn_l, btn_r, pause;
    logic [7:0] rgb_out;
    logic       frame_tick, miss_pulse;

    int errors = 0;
    int checks = 0;
    int misses = 0;
    bit in_reset;

    int m_pad, m_bx, m_by;
    bit m_right, m_down;

    int qh[$], qv[$];
    bit qp[$], qbl[$], qbr[$];

    vga_pong_render dut (
        .Clk_Pixel      (clk),
        .Rst_N          (rst_n),
        .H_Pixel_Count  (hcnt),
        .V_Line_Count   (vcnt),
        .H_Enable_Write (h_en),
        .V_Enable_Write (v_en),
        .Btn_Left       (btn_l),
        .Btn_Right      (btn_r),
        .Pause          (pause),
        .Rgb_Out        (rgb_out),
        .Frame_Tick     (frame_tick),
        .Miss_Pulse     (miss_pulse)
    );

    always #20 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_pad = 288; m_bx = 316; m_by = 236; m_right = 1'b1; m_down = 1'b0;
    endtask

    // One frame of game rules on whole integers; returns whether the ball was lost.
    task automatic modelFrame(input bit bl, input bit br, output bit miss);
        int bottom;
        miss = 1'b0;
        if (bl && !br) m_pad = (m_pad - 4 < LIM) ? LIM : m_pad - 4;
        if (br && !bl) m_pad = (m_pad + 4 > PADMAX) ? PADMAX : m_pad + 4;
        if (m_right) begin
            if (m_bx + 2 >= XMAX) begin m_bx = XMAX; m_right = 1'b0; end
            else m_bx += 2;
        end else begin
            if (m_bx - 2 <= LIM) begin m_bx = LIM; m_right = 1'b1; end
            else m_bx -= 2;
        end
        bottom = m_by + 8;
        if (!m_down) begin
            if (m_by - 2 <= LIM) begin m_by = LIM; m_down = 1'b1; end
            else m_by -= 2;
        end else if (bottom <= 456 && bottom + 2 >= 456 && m_bx + 8 > m_pad && m_bx < m_pad + 64) begin
            m_by = 448; m_down = 1'b0;
        end else if (m_by + 2 >= 472) begin
            m_bx = 316; m_by = 236; m_down = 1'b0; miss = 1'b1;
        end else begin
            m_by += 2;
        end
    endtask

    function automatic bit enH(int h);
        return h >= H_OFF && h < H_OFF + 640;
    endfunction

    function automatic bit enV(int v);
        return v >= V_OFF && v < V_OFF + 480;
    endfunction

    function automatic int colourOf(int h, int v);
        int x, y;
        if (!(enH(h) && enV(v))) return 0;
        x = h - H_OFF;
        y = v - V_OFF;
        if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 'hFC;
        if (x >= m_pad && x < m_pad + 64 && y >= 456 && y < 464) return 'h1C;
        if (BORDER && (x < 4 || x >= 636 || y < 4)) return 'hE0;
        return 'h00;
    endfunction

    // One pixel clock: new count after the edge, enables for the previous count, checks at negedge.
    task automatic applyStimulus(input int h, input int v);
        bit miss_exp;
        @(posedge clk);
        qp.push_front(pause); qbl.push_front(btn_l); qbr.push_front(btn_r);
        #1;
        h_en = enH(qh[0]);
        v_en = enV(qv[0]);
        hcnt = 10'(h);
        vcnt = 10'(v);
        qh.push_front(h); qv.push_front(v);
        if (qh.size() > 8) begin
            void'(qh.pop_back()); void'(qv.pop_back());
            void'(qp.pop_back()); void'(qbl.pop_back()); void'(qbr.pop_back());
        end
        @(negedge clk);
        if (in_reset) begin
            checkOutput("reset_rgb", int'(rgb_out), 0);
            checkOutput("reset_frame_tick", int'(frame_tick), 0);
            checkOutput("reset_miss", int'(miss_pulse), 0);
        end else begin
            miss_exp = 1'b0;
            if (qh[5] == 0 && qv[5] == BLANK_V && !qp[3]) modelFrame(qbl[4], qbr[4], miss_exp);
            if (miss_exp) misses++;
            checkOutput("frame_tick", int'(frame_tick), int'(qh[1] == 0 && qv[1] == BLANK_V));
            checkOutput("miss_pulse", int'(miss_pulse), int'(miss_exp));
            checkOutput("rgb", int'(rgb_out), colourOf(qh[2], qv[2]));
        end
    endtask

    task automatic probeHV(input int h, input int v, output int val);
        applyStimulus(h, v);
        applyStimulus(1, 0);
        applyStimulus(2, 0);
        val = int'(rgb_out);
    endtask

    task automatic probe(input string name, input int x, input int y, input int expected);
        int val;
        probeHV(x + H_OFF, y + V_OFF, val);
        checkOutput(name, val, expected);
    endtask

    task automatic doReset();
        #5 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_rgb", int'(rgb_out), 0);
        checkOutput("async_reset_frame_tick", int'(frame_tick), 0);
        checkOutput("async_reset_miss", int'(miss_pulse), 0);
        in_reset = 1'b1;
        repeat (8) applyStimulus(1, 0);
        modelReset();
        rst_n = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic doFrame();
        int x, y, h, v;
        applyStimulus(0, BLANK_V);
        for (int i = 1; i <= 8; i++) applyStimulus(i, BLANK_V);
        for (int i = 0; i < 8; i++) begin
            x = m_bx - 2 + int'($urandom_range(0, 11));
            y = m_by - 2 + int'($urandom_range(0, 11));
            applyStimulus(x + H_OFF, y + V_OFF);
        end
        for (int i = 0; i < 6; i++) begin
            x = m_pad - 2 + int'($urandom_range(0, 67));
            y = 454 + int'($urandom_range(0, 11));
            applyStimulus(x + H_OFF, y + V_OFF);
        end
        for (int i = 0; i < 3; i++) begin
            h = int'($urandom_range(0, 799));
            v = int'($urandom_range(0, 520));
            if (h == 0 && v == BLANK_V) h = 1;
            applyStimulus(h, v);
        end
    endtask

    initial begin
        int val, bx0, by0, r;
        rst_n = 1'b1; btn_l = 1'b0; btn_r = 1'b0; pause = 1'b0;
        hcnt = '0; vcnt = '0; h_en = 1'b0; v_en = 1'b0; in_reset = 1'b1;
        modelReset();
        for (int i = 0; i < 8; i++) begin
            qh.push_back(0); qv.push_back(0); qp.push_back(1'b0); qbl.push_back(1'b0); qbr.push_back(1'b0);
        end
        #3 rst_n = 1'b0;
        repeat (8) applyStimulus(1, 0);
        rst_n = 1'b1;
        in_reset = 1'b0;

        probeHV(144, 31, val);  checkOutput("t2_first_active", val, BORDER ? 'hE0 : 'h00);
        probeHV(143, 31, val);  checkOutput("t2_before_active", val, 0);
        probeHV(300, 30, val);  checkOutput("t2_line_above", val, 0);
        probeHV(784, 100, val); checkOutput("t2_after_active", val, 0);
        probeHV(783, 510, val); checkOutput("t2_last_active", val, BORDER ? 'hE0 : 'h00);
        probe("t1_ball_origin", 316, 236, 'hFC);
        probe("t1_ball_corner", 323, 243, 'hFC);
        probe("t1_ball_right_edge", 324, 236, 'h00);
        probe("t1_pad_left", 288, 456, 'h1C);
        probe("t1_pad_corner", 351, 463, 'h1C);
        probe("t1_pad_right_edge", 352, 456, 'h00);
        probe("t1_pad_left_edge", 287, 456, 'h00);

        for (int x = 310; x <= 321; x++) applyStimulus(x + H_OFF, 236 + V_OFF);
        doReset();
        probe("t1_ball_after_reset", 316, 236, 'hFC);

        btn_r = 1'b1;
        repeat (80) doFrame();
        checkOutput("t3_model_pad", m_pad, PADMAX);
        probe("t3_pad_at_limit", PADMAX, 456, 'h1C);
        probe("t3_pad_right_end", 639 - LIM, 463, 'h1C);
        probe("t3_left_of_pad", PADMAX - 1, 456, 'h00);
        btn_l = 1'b1;
        repeat (3) doFrame();
        checkOutput("t3_both_hold_model", m_pad, PADMAX);
        probe("t3_both_hold_pad", 639 - LIM, 460, 'h1C);
        btn_l = 1'b0; btn_r = 1'b0;

        bx0 = m_bx; by0 = m_by;
        pause = 1'b1;
        repeat (3) doFrame();
        pause = 1'b0;
        checkOutput("t6_model_frozen", m_bx, bx0);
        probe("t6_ball_frozen", bx0, by0, 'hFC);
        probe("t6_left_of_ball", bx0 - 1, by0, 'h00);
        probe("t6_right_of_ball", bx0 + 8, by0, 'h00);

        repeat (NX - 83) doFrame();
        checkOutput("t4_model_at_wall", m_bx, XMAX);
        checkOutput("t4_model_dir_left", int'(m_right), 0);
        probe("t4_ball_at_wall", XMAX + 7, m_by, 'hFC);
        doFrame();
        checkOutput("t4_model_back", m_bx, XMAX - 2);
        probe("t4_wall_gap", XMAX + 7, m_by, 'h00);
        probe("t4_ball_back", XMAX - 2, m_by, 'hFC);

        for (int f = 0; f < 500; f++) begin
            r = int'($urandom_range(0, 7));
            if (r < 4) begin
                btn_r = (m_pad + 32 < m_bx);
                btn_l = (m_pad + 32 > m_bx + 8);
            end else begin
                btn_l = (r == 4) || (r == 6);
                btn_r = (r == 5) || (r == 6);
            end
            pause = ($urandom_range(0, 15) == 0);
            if (f == 150) begin
                applyStimulus(0, BLANK_V);
                applyStimulus(1, BLANK_V);
                applyStimulus(2, BLANK_V);
                doReset();
                probe("reset_mid_update_ball", 316, 236, 'hFC);
            end
            doFrame();
        end
        pause = 1'b0;
        repeat (4) applyStimulus(1, 0);

        $display("[TB] predicted ball losses during run: %0d", misses);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
